turn_signal_ctrl: RTL and testbench

- Front-end controller that drives the tail-light sequencer.
- Synchronizes and debounces the raw left, right and hazard switches, then arbitrates them into one mode with a small state machine.
- Produces the sequencer's step strobe (`enable`), side select (`left_right`) and active flag (`current_state`), plus a hazard flag and step phase.
- Sits between the board switches and the light sequencer; all outputs are registered.

---
 rtl/turn_signal_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_turn_signal_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/turn_signal_ctrl.sv
// -----------------------------------------------------------------------------
// turn_signal_ctrl
//
// Front-end controller for the tail-light sequencer. The raw turn and hazard
// switches are synchronized and debounced. The debounced values are decoded
// into one request, and a small FSM arbitrates that request into a single mode.
// From that mode the block produces the sequencer's step strobe, side select,
// active flag, hazard flag and step phase. Every output is registered.
//
// Optional feature macro: TURN_SIGNAL_HAZARD_EN
//   defined     - the hazard switch is conditioned and decoded with top priority.
//   not defined - sw_hazard is ignored and no logic is built for it. The HAZARD
//                 state is unreachable, and hazard stays 0.
//
// Parameters
//   TICK_DIV        clock cycles per sequencer step (>= 2)
//   DEBOUNCE_CYCLES stable synchronized cycles needed to accept a change (>= 1)
//
// Ports
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   sw_left        in   raw left-turn switch (asynchronous)
//   sw_right       in   raw right-turn switch (asynchronous)
//   sw_hazard      in   raw hazard switch (asynchronous)
//   enable         out  one-cycle step strobe to the sequencer
//   left_right     out  1 = left side, 0 = right side
//   current_state  out  1 while a mode is active; 0 clears the sequencer
//   hazard         out  1 while in HAZARD
//   phase[1:0]     out  step index within the 4-step light cycle
// -----------------------------------------------------------------------------
module turn_signal_ctrl #(
    parameter int TICK_DIV        = 12_500_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sw_left,
    input  logic       sw_right,
    input  logic       sw_hazard,
    output logic       enable,
    output logic       left_right,
    output logic       current_state,
    output logic       hazard,
    output logic [1:0] phase
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    // A change is accepted on the edge where the count would reach
    // DEBOUNCE_CYCLES, so the comparison uses one less than that value.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    // Switch vector layout: bit 0 = left, bit 1 = right, bit 2 = hazard (optional)
`ifdef TURN_SIGNAL_HAZARD_EN
    localparam int NSW = 3;
    logic [NSW-1:0] raw_sw;
    assign raw_sw = {sw_hazard, sw_right, sw_left};
`else
    localparam int NSW = 2;
    logic [NSW-1:0] raw_sw;
    logic           unused_sw_hazard;
    assign raw_sw           = {sw_right, sw_left};
    assign unused_sw_hazard = sw_hazard;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEFT   = 3'd1,
        S_RIGHT  = 3'd2,
        S_HAZARD = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    function automatic logic is_active(input state_t s);
        return (s == S_LEFT) || (s == S_RIGHT) || (s == S_HAZARD);
    endfunction

    // ------------------------------------------------------------------
    // Input conditioning: 2-flop synchronizer + per-switch debounce
    // ------------------------------------------------------------------
    logic [NSW-1:0]  sync1_q;
    logic [NSW-1:0]  sync2_q;
    logic [NSW-1:0]  db_q;
    logic [NSW-1:0]  db_d;
    logic [DB_W-1:0] db_cnt_q [NSW];
    logic [DB_W-1:0] db_cnt_d [NSW];

    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < NSW; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_d[i]     = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < NSW; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= raw_sw;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Request decode: hazard wins; left/right only when exactly one is set
    // ------------------------------------------------------------------
    state_t req;

    always_comb begin
        req = S_IDLE;
        case ({db_q[1], db_q[0]})
            2'b01:   req = S_LEFT;
            2'b10:   req = S_RIGHT;
            default: req = S_IDLE;
        endcase
`ifdef TURN_SIGNAL_HAZARD_EN
        if (db_q[2]) begin
            req = S_HAZARD;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Mode FSM, tick counter and phase
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;
    logic [1:0]        phase_q;
    logic [1:0]        phase_d;
    logic              enable_q;
    logic              enable_d;
    logic              current_state_q;
    logic              left_right_q;
    logic              hazard_q;
    logic              stay;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_GAP: begin
                state_d = req;
            end
            S_LEFT, S_RIGHT, S_HAZARD: begin
                if (req == state_q) begin
                    state_d = state_q;
                end else if (req == S_IDLE) begin
                    state_d = S_IDLE;
                end else begin
                    // Direction change: insert a one-cycle blank so the
                    // sequencer is cleared before the new side starts.
                    state_d = S_GAP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The tick counter and phase keep running only while the same active
    // mode persists. Any mode entry or exit restarts them from 0.
    always_comb begin
        stay     = is_active(state_q) && (state_d == state_q);
        enable_d = stay && (tick_q == TICK_LAST);
        tick_d   = '0;
        phase_d  = 2'd0;
        if (stay) begin
            tick_d  = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
            phase_d = phase_q + {1'b0, enable_d};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            tick_q          <= '0;
            phase_q         <= 2'd0;
            enable_q        <= 1'b0;
            current_state_q <= 1'b0;
            left_right_q    <= 1'b0;
            hazard_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            tick_q          <= tick_d;
            phase_q         <= phase_d;
            enable_q        <= enable_d;
            // Flags are decoded from the next state, so they change on the
            // same edge as the state itself.
            current_state_q <= is_active(state_d);
            left_right_q    <= (state_d == S_LEFT) || (state_d == S_HAZARD);
            hazard_q        <= (state_d == S_HAZARD);
        end
    end

    assign enable        = enable_q;
    assign left_right    = left_right_q;
    assign current_state = current_state_q;
    assign hazard        = hazard_q;
    assign phase         = phase_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
module tb_turn_signal_ctrl;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;

`ifdef TURN_SIGNAL_HAZARD_EN
    localparam int HZ_EN = 1;
`else
    localparam int HZ_EN = 0;
`endif

    logic       clock;
    logic       reset_n;
    logic       sw_left;
    logic       sw_right;
    logic       sw_hazard;
    logic       enable;
    logic       left_right;
    logic       current_state;
    logic       hazard;
    logic [1:0] phase;

    int n_checks;
    int n_errors;

    turn_signal_ctrl #(
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sw_left      (sw_left),
        .sw_right     (sw_right),
        .sw_hazard    (sw_hazard),
        .enable       (enable),
        .left_right   (left_right),
        .current_state(current_state),
        .hazard       (hazard),
        .phase        (phase)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle, so sampling is away from the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic int outs();
        return int'({enable, left_right, current_state, hazard, phase});
    endfunction

    initial begin
        int exp_en;
        int exp_ph;
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        sw_left   = 1'b0;
        sw_right  = 1'b0;
        sw_hazard = 1'b0;

        // Reset state
        step(2);
        check_eq("reset_outs", outs(), 0);
        reset_n = 1'b1;
        step(3);
        check_eq("idle_outs", outs(), 0);

        // Left turn: debounced after 5 edges, active on edge 6
        sw_left = 1'b1;
        step(5);
        check_eq("left_e5_cs", int'(current_state), 0);
        step(1);
        check_eq("left_e6_cs", int'(current_state), 1);
        check_eq("left_e6_lr", int'(left_right), 1);
        check_eq("left_e6_ph", int'(phase), 0);
        check_eq("left_e6_en", int'(enable), 0);
        for (int k = 1; k <= 20; k++) begin
            step(1);
            exp_en = (k % 4 == 0) ? 1 : 0;
            exp_ph = (k / 4) % 4;
            check_eq($sformatf("left_k%0d_en", k), int'(enable), exp_en);
            check_eq($sformatf("left_k%0d_ph", k), int'(phase), exp_ph);
        end
        check_eq("left_hz", int'(hazard), 0);

        // Direction change LEFT -> RIGHT through one GAP cycle
        sw_left  = 1'b0;
        sw_right = 1'b1;
        step(5);
        check_eq("dir_e5_cs", int'(current_state), 1);
        step(1);
        check_eq("gap_cs", int'(current_state), 0);
        check_eq("gap_lr", int'(left_right), 0);
        check_eq("gap_ph", int'(phase), 0);
        check_eq("gap_en", int'(enable), 0);
        step(1);
        check_eq("right_cs", int'(current_state), 1);
        check_eq("right_lr", int'(left_right), 0);
        check_eq("right_ph", int'(phase), 0);
        for (int j = 1; j <= 4; j++) begin
            step(1);
            check_eq($sformatf("right_j%0d_en", j), int'(enable), (j == 4) ? 1 : 0);
            check_eq($sformatf("right_j%0d_ph", j), int'(phase), (j == 4) ? 1 : 0);
        end

        // Release: current_state falls on edge 6, no enable afterwards
        sw_right = 1'b0;
        step(5);
        check_eq("rel_e5_cs", int'(current_state), 1);
        step(1);
        check_eq("rel_e6_cs", int'(current_state), 0);
        check_eq("rel_e6_ph", int'(phase), 0);
        for (int j = 0; j < 10; j++) begin
            step(1);
            check_eq($sformatf("rel_after%0d_en", j), int'(enable), 0);
        end

        // Glitch rejection: 2-cycle pulse on sw_right
        sw_right = 1'b1;
        step(2);
        sw_right = 1'b0;
        for (int j = 0; j < 12; j++) begin
            step(1);
            check_eq($sformatf("glitch%0d_cs", j), int'(current_state), 0);
            check_eq($sformatf("glitch%0d_en", j), int'(enable), 0);
        end

        // Conflict: both directions -> IDLE; adding hazard -> HAZARD if built
        sw_left  = 1'b1;
        sw_right = 1'b1;
        step(10);
        check_eq("conflict_outs", outs(), 0);
        sw_hazard = 1'b1;
        step(5);
        check_eq("hz_e5_cs", int'(current_state), 0);
        step(1);
        check_eq("hz_e6_cs", int'(current_state), HZ_EN);
        check_eq("hz_e6_hz", int'(hazard), HZ_EN);
        check_eq("hz_e6_lr", int'(left_right), HZ_EN);
        step(3);
        check_eq("hz_j3_en", int'(enable), 0);
        step(1);
        check_eq("hz_j4_en", int'(enable), HZ_EN);
        check_eq("hz_j4_ph", int'(phase), HZ_EN);

        // Return to idle, then enter LEFT for the reset test
        sw_left   = 1'b0;
        sw_right  = 1'b0;
        sw_hazard = 1'b0;
        step(10);
        check_eq("idle2_outs", outs(), 0);
        sw_left = 1'b1;
        step(6);
        check_eq("pre_rst_cs", int'(current_state), 1);
        check_eq("pre_rst_lr", int'(left_right), 1);

        // Asynchronous reset mid-cycle: outputs clear before the next edge
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_outs", outs(), 0);
        step(1);
        reset_n = 1'b1;
        step(1);
        check_eq("post_rst_outs", outs(), 0);
        // Sampling restarts from zero: activation on edge 6 after release
        step(4);
        check_eq("post_rst_e5_cs", int'(current_state), 0);
        step(1);
        check_eq("post_rst_e6_cs", int'(current_state), 1);
        check_eq("post_rst_e6_lr", int'(left_right), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
